probe_byte_sequencer: RTL and testbench

//  Upstream feeder for the UART transmit path in the hardware-debugger top level.
//  On a capture pulse, latches a wide probe word and streams it to the uart as

---
 rtl/probe_byte_sequencer_pkg.sv | 23 ++
 rtl/probe_byte_sequencer_if.sv | 20 ++
 rtl/probe_byte_sequencer_ack_timer.sv | 29 ++
 rtl/probe_byte_sequencer.sv | 143 ++++++++++++++
 tb/tb_probe_byte_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/probe_byte_sequencer_pkg.sv
// Shared types and constants for the probe byte sequencer.
// PROBE_SYNC_BYTE_EN adds the sync-byte prefix to every frame.
package probe_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } seq_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int unsigned frame_len(input int unsigned num_bytes);
`ifdef PROBE_SYNC_BYTE_EN
        return num_bytes + 1;
`else
        return num_bytes;
`endif
    endfunction

endpackage

// File: rtl/probe_byte_sequencer_if.sv
// UART transmit handshake between the probe sequencer (master) and the uart (slave).
interface probe_byte_sequencer_if;

    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;

    modport master (
        output transmit,
        output tx_byte,
        input  is_transmitting
    );

    modport slave (
        input  transmit,
        input  tx_byte,
        output is_transmitting
    );

endinterface

// File: rtl/probe_byte_sequencer_ack_timer.sv
// Saturating acknowledge timer; expired holds once the count reaches ACK_TIMEOUT-1.
module probe_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic iCE_CLK,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/probe_byte_sequencer.sv
// Latches a probe word on capture and streams it LSB byte first to the uart,
// one byte in flight at a time. PROBE_SYNC_BYTE_EN prefixes each frame with SYNC_BYTE.
module probe_byte_sequencer
    import probe_seq_pkg::*;
#(
    parameter int unsigned NUM_BYTES   = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                   iCE_CLK,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [8*NUM_BYTES-1:0] probe_data,
    probe_byte_sequencer_if.master uart,
    output logic                   busy,
    output logic                   done,
    output logic                   dropped,
    output logic                   ack_error
);

    localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);

    seq_state_t             state, state_next;
    logic [8*NUM_BYTES-1:0] shadow;
    logic [IDX_W-1:0]       idx;
    logic                   transmit_r;
    logic [7:0]             tx_byte_r;
    logic [7:0]             cur_byte;
    logic [7:0]             send_byte;
    logic                   last_byte;
    logic                   sync_pending;
    logic                   load, inc, sync_clr;
    logic                   tmr_clr, tmr_en, tmr_expired, set_err;

    probe_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .iCE_CLK (iCE_CLK),
        .rst     (rst),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        cur_byte = '0;
        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            if (idx == IDX_W'(k)) cur_byte = shadow[8*k +: 8];
        end
    end

    assign send_byte = sync_pending ? SYNC_BYTE : cur_byte;
    assign last_byte = (idx == IDX_W'(NUM_BYTES - 1));

    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        inc        = 1'b0;
        sync_clr   = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                tmr_clr    = 1'b1;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                tmr_en = 1'b1;
                if (uart.is_transmitting) begin
                    state_next = WAIT_DONE;
                end else if (tmr_expired) begin
                    set_err    = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart.is_transmitting) begin
                    if (sync_pending) begin
                        sync_clr   = 1'b1;
                        state_next = SEND;
                    end else if (last_byte) begin
                        state_next = FINISH;
                    end else begin
                        inc        = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // transmit/tx_byte are registered out of SEND, giving the capture-to-transmit latency of two cycles
    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            idx        <= '0;
            ack_error  <= 1'b0;
            transmit_r <= 1'b0;
            tx_byte_r  <= '0;
        end else begin
            transmit_r <= (state == SEND);
            if (state == SEND) tx_byte_r <= send_byte;
            if (load) begin
                shadow    <= probe_data;
                idx       <= '0;
                ack_error <= 1'b0;
            end else begin
                if (inc)     idx       <= idx + 1'b1;
                if (set_err) ack_error <= 1'b1;
            end
        end
    end

`ifdef PROBE_SYNC_BYTE_EN
    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst)           sync_pending <= 1'b0;
        else if (load)     sync_pending <= 1'b1;
        else if (sync_clr) sync_pending <= 1'b0;
    end
`else
    assign sync_pending = 1'b0;
`endif

    assign uart.transmit = transmit_r;
    assign uart.tx_byte  = tx_byte_r;
    assign busy          = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_DONE);
    assign done          = (state == FINISH);
    assign dropped       = capture && (state != IDLE);

endmodule

// File: tb/tb_probe_byte_sequencer.sv
// Directed bench for probe_byte_sequencer with a simple uart busy-line model;
// expects the sync prefix when PROBE_SYNC_BYTE_EN is defined.
module tb_probe_byte_sequencer;

    logic        iCE_CLK = 1'b0;
    logic        rst;
    logic        capture;
    logic [31:0] probe_data;
    logic        busy, done, dropped, ack_error;

    probe_byte_sequencer_if u ();

    probe_byte_sequencer #(
        .NUM_BYTES   (4),
        .ACK_TIMEOUT (64)
    ) dut (
        .iCE_CLK    (iCE_CLK),
        .rst        (rst),
        .capture    (capture),
        .probe_data (probe_data),
        .uart       (u),
        .busy       (busy),
        .done       (done),
        .dropped    (dropped),
        .ack_error  (ack_error)
    );

    always #42 iCE_CLK = ~iCE_CLK;

    typedef struct {
        logic [31:0]     data;
        bit              acks;
        logic [0:3][7:0] exp;
        bit              exp_err;
        bit              drop_mid;
        bit              drop_fin;
    } vec_t;

    vec_t        vecs[4];
    vec_t        vr;
    int unsigned n_vec  = 0;
    int unsigned n_bad  = 0;
    logic [7:0]  seen_q[$];
    int unsigned done_cnt  = 0;
    int unsigned pace_viol = 0;
    bit          uart_ack_en = 1'b1;
    int unsigned uart_cnt    = 0;

    initial u.is_transmitting = 1'b0;

    // uart model: busy line rises one cycle after transmit and stays high 1250 cycles
    always @(posedge iCE_CLK) begin
        if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) u.is_transmitting <= 1'b0;
        end else if (u.transmit && uart_ack_en) begin
            u.is_transmitting <= 1'b1;
            uart_cnt          <= 1250;
        end
    end

    always @(negedge iCE_CLK) begin
        if (!rst) begin
            if (u.transmit) begin
                seen_q.push_back(u.tx_byte);
                if (u.is_transmitting) pace_viol++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; the return point is the idle cycle after done.
    task automatic run_frame(input vec_t v);
        logic [7:0]  want[$];
        int unsigned lat;
        int unsigned n;
        bit          got;
        want.delete();
`ifdef PROBE_SYNC_BYTE_EN
        want.push_back(8'hA5);
`endif
        for (int i = 0; i < 4; i++) want.push_back(v.exp[i]);
        seen_q.delete();
        done_cnt    = 0;
        pace_viol   = 0;
        uart_ack_en = v.acks;
        probe_data  = v.data;
        capture     = 1'b1;
        #1 chk("capture_accepted", {31'd0, dropped}, 32'd0);
        @(negedge iCE_CLK);
        capture = 1'b0;
        chk("busy_after_capture", {31'd0, busy}, 32'd1);
        chk("err_cleared", {31'd0, ack_error}, 32'd0);
        lat = 1;
        while (!u.transmit && lat < 10) begin
            @(negedge iCE_CLK);
            lat++;
        end
        chk("first_tx_latency", lat, 32'd2);
        if (!v.acks) begin
            n = 0;
            while (!ack_error && n < 200) begin
                @(negedge iCE_CLK);
                n++;
            end
            chk("ack_timeout_cycles", n, 32'd64);
        end
        if (v.drop_mid) begin
            repeat (8) @(negedge iCE_CLK);
            probe_data = ~v.data;
            capture    = 1'b1;
            #1 chk("dropped_mid", {31'd0, dropped}, 32'd1);
            @(negedge iCE_CLK);
            capture    = 1'b0;
            probe_data = v.data;
        end
        got = 1'b0;
        for (int c = 0; c < 10000 && !got; c++) begin
            @(negedge iCE_CLK);
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (v.drop_fin) begin
            probe_data = ~v.data;
            capture    = 1'b1;
            #1 chk("dropped_finish", {31'd0, dropped}, 32'd1);
        end
        @(negedge iCE_CLK);
        capture    = 1'b0;
        probe_data = v.data;
        chk("done_count", done_cnt, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("ack_error", {31'd0, ack_error}, {31'd0, v.exp_err});
        chk("pacing", pace_viol, 32'd0);
        chk("byte_count", seen_q.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            chk($sformatf("byte%0d", i), (i < seen_q.size()) ? {24'd0, seen_q[i]} : 32'hxxxx_xxxx,
                {24'd0, want[i]});
        end
    endtask

    initial begin
        bit got;
        vecs[0] = '{data: 32'hDEADBEEF, acks: 1'b1, exp: '{8'hEF, 8'hBE, 8'hAD, 8'hDE},
                    exp_err: 1'b0, drop_mid: 1'b1, drop_fin: 1'b0};
        vecs[1] = '{data: 32'h12345678, acks: 1'b0, exp: '{8'h78, 8'h56, 8'h34, 8'h12},
                    exp_err: 1'b1, drop_mid: 1'b0, drop_fin: 1'b0};
        vecs[2] = '{data: 32'h01020304, acks: 1'b1, exp: '{8'h04, 8'h03, 8'h02, 8'h01},
                    exp_err: 1'b0, drop_mid: 1'b0, drop_fin: 1'b1};
        vecs[3] = '{data: 32'h80FF017F, acks: 1'b1, exp: '{8'h7F, 8'h01, 8'hFF, 8'h80},
                    exp_err: 1'b0, drop_mid: 1'b0, drop_fin: 1'b0};
        vr      = '{data: 32'hAABBCCDD, acks: 1'b1, exp: '{8'hDD, 8'hCC, 8'hBB, 8'hAA},
                    exp_err: 1'b0, drop_mid: 1'b0, drop_fin: 1'b0};

        rst        = 1'b1;
        capture    = 1'b0;
        probe_data = '0;
        repeat (3) @(negedge iCE_CLK);
        rst = 1'b0;
        @(negedge iCE_CLK);
        chk("rst_transmit", {31'd0, u.transmit}, 32'd0);
        chk("rst_tx_byte", {24'd0, u.tx_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack_error", {31'd0, ack_error}, 32'd0);

        // frames run back to back: each capture lands in the idle cycle right after done
        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // reset while byte 2 is on the wire
        seen_q.delete();
        done_cnt    = 0;
        uart_ack_en = 1'b1;
        probe_data  = vr.data;
        capture     = 1'b1;
        @(negedge iCE_CLK);
        capture = 1'b0;
`ifdef PROBE_SYNC_BYTE_EN
        for (int c = 0; c < 10000 && seen_q.size() < 4; c++) @(negedge iCE_CLK);
`else
        for (int c = 0; c < 10000 && seen_q.size() < 3; c++) @(negedge iCE_CLK);
`endif
        repeat (20) @(negedge iCE_CLK);
        chk("pre_rst_tx_byte", {24'd0, u.tx_byte}, 32'h0000_00BB);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_transmit", {31'd0, u.transmit}, 32'd0);
        chk("arst_tx_byte", {24'd0, u.tx_byte}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_dropped", {31'd0, dropped}, 32'd0);
        chk("arst_ack_error", {31'd0, ack_error}, 32'd0);
        repeat (2) @(negedge iCE_CLK);
        rst = 1'b0;
        repeat (30) @(negedge iCE_CLK);
        chk("no_done_after_rst", done_cnt, 32'd0);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge iCE_CLK);
            if (!u.is_transmitting) got = 1'b1;
        end
        chk("uart_idle", {31'd0, got}, 32'd1);
        run_frame(vr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
